// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Boot loader placed in front of the processor's instruction memory.
//   A program image arrives over an 8N1 UART line as a 4-byte little-endian
//   length header N followed by N little-endian 32-bit words. Each word is
//   written to imem through a one-cycle write strobe. The processor core is
//   held in reset until the last word has been written.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   asynchronous reset, active-low
//   rxd       in   UART receive line (asynchronous, idle high, LSB first)
//   mem_addr  out  imem word index of the current write
//   mem_data  out  word to write
//   mem_we    out  one-cycle write strobe
//   proc_rst  out  active-high reset for the processor core
//   done      out  image fully loaded (sticky)
//   err       out  framing or length error (sticky)
//   word_cnt  out  number of words written so far
//
// Handshake: there is no back-pressure anywhere. The receiver produces a
// one-cycle byte_valid (or frame_err) pulse per character, and the loader
// must consume it in that cycle; mem_we is likewise a fire-and-forget pulse
// with mem_addr/mem_data valid only while it is high.
//
// The two FSM state registers (rx_state, ld_state) are plain named enums so
// they can be probed hierarchically.

module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD         = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        proc_rst,
    output logic        done,
    output logic        err,
    output logic [31:0] word_cnt
);

    // Timers count down to zero, so load one less than the wanted interval.
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] MAX_LEN = 32'(WORD);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

    rx_state_t   rx_state;
    ld_state_t   ld_state;

    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_prev;
    logic [15:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        frame_err;

    logic [1:0]  bidx;
    logic [31:0] acc;
    logic [31:0] asm_word;
    logic [31:0] img_len;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    // UART receiver. Sampling points sit mid-bit: half a bit after the
    // detected start edge, then every full bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rxd_prev && !rxd_s2) begin
                        rx_state <= R_START;
                        bit_tmr  <= HALF_M1;
                    end
                end
                R_START: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else if (!rxd_s2) begin
                        rx_state <= R_DATA;
                        bit_tmr  <= FULL_M1;
                        bit_idx  <= '0;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        rx_state <= R_IDLE;
                    end
                end
                R_DATA: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else begin
                        shreg   <= {rxd_s2, shreg[7:1]};
                        bit_tmr <= FULL_M1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                R_STOP: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else begin
                        if (rxd_s2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // Returning mid stop bit leaves time to catch a
                        // back-to-back start edge.
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Accumulator with the incoming byte dropped into lane bidx; shared by
    // the length header and the data words.
    always_comb begin
        asm_word = acc;
        asm_word[{bidx, 3'b000} +: 8] = rx_byte;
    end

    // Loader FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state <= L_LEN;
            bidx     <= '0;
            acc      <= '0;
            img_len  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            word_cnt <= '0;
            proc_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (ld_state)
                L_LEN: begin
                    if (frame_err) begin
                        ld_state <= L_ERR;
                        err      <= 1'b1;
                    end else if (byte_valid) begin
                        acc  <= asm_word;
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            if (asm_word == 32'd0) begin
                                ld_state <= L_DONE;
                                done     <= 1'b1;
                                proc_rst <= 1'b0;
                            end else if (asm_word > MAX_LEN) begin
                                ld_state <= L_ERR;
                                err      <= 1'b1;
                            end else begin
                                ld_state <= L_DATA;
                                img_len  <= asm_word;
                            end
                        end
                    end
                end
                L_DATA: begin
                    if (frame_err) begin
                        ld_state <= L_ERR;
                        err      <= 1'b1;
                    end else if (mem_we && word_cnt == img_len) begin
                        // word_cnt already counts the write now on the bus.
                        ld_state <= L_DONE;
                        done     <= 1'b1;
                        proc_rst <= 1'b0;
                    end else if (byte_valid) begin
                        acc  <= asm_word;
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_addr <= word_cnt;
                            mem_data <= asm_word;
                            word_cnt <= word_cnt + 32'd1;
                        end
                    end
                end
                L_DONE: begin
                    done     <= 1'b1;
                    proc_rst <= 1'b0;
                end
                L_ERR: begin
                    err      <= 1'b1;
                    proc_rst <= 1'b1;
                end
                default: ld_state <= L_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
`timescale 1ns/1ps

module tb_uart_imem_loader;

    localparam int CPB  = 16;
    localparam int WORD = 4096;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        proc_rst;
    logic        done;
    logic        err;
    logic [31:0] word_cnt;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORD(WORD)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .proc_rst(proc_rst), .done(done), .err(err), .word_cnt(word_cnt)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          we_cnt = 0;
    int          last_we_cyc = 0;
    logic        done_prev = 1'b0;
    logic [63:0] exp_q[$];        // {addr, data} of every write the model predicts
    logic [31:0] img_words[$];    // words of the image being sent

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every write must be the next one the model predicted
    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {mem_addr, mem_data}, 64'hx);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("we_addr", mem_addr, e[63:32]);
                    check("we_data", mem_data, e[31:0]);
                end
            end
            if (done && !done_prev && we_cnt > 0)
                check("done_after_last_we", 32'(cyc - last_we_cyc), 1);
        end
        done_prev = done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        wait_cyc(3);
        rst = 1'b1;
        we_cnt = 0;
        wait_cyc(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
        rxd = 1'b1;
        wait_cyc(gap);
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(CPB);
        end
        rxd = stop_ok;
        wait_cyc(CPB);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++)
            send_byte(8'(w >> (8 * k)), 1'b1, $urandom_range(0, gap_max));
    endtask

    // reference model: image of N words -> N writes at addresses 0..N-1
    task automatic send_image(input int gap_max);
        int n;
        n = img_words.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back({32'(i), img_words[i]});
        send_word(32'(n), gap_max);
        for (int i = 0; i < n; i++)
            send_word(img_words[i], gap_max);
    endtask

    task automatic check_loaded(input string tag, input int n);
        wait_cyc(4);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_proc_rst"}, proc_rst, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_word_cnt"}, word_cnt, 32'(n));
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(n));
        check({tag, "_exp_left"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int          n;
        logic [31:0] wc_before;

        // reset state
        do_reset();
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_we", mem_we, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_proc_rst", proc_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // directed two-word image
        img_words = '{32'h12345678, 32'hDEADBEEF};
        send_image(0);
        check_loaded("two_words", 2);
        // bytes after done, including a bad stop bit, change nothing
        send_byte(8'h55, 1'b0, 3);
        send_word(32'h00000001, 2);
        wait_cyc(4);
        check("done_ignore_err", err, 0);
        check("done_ignore_we", 32'(we_cnt), 2);
        check("done_ignore_cnt", word_cnt, 2);

        // zero-length header
        do_reset();
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        check("n0_done_before", done, 0);
        send_byte(8'h00, 1'b1, 0);
        check("n0_done", done, 1);
        check("n0_proc_rst", proc_rst, 0);
        wait_cyc(10);
        check("n0_we", 32'(we_cnt), 0);

        // N = 4097 exceeds imem depth
        do_reset();
        send_word(32'h00001001, 0);
        wait_cyc(2);
        check("len_err", err, 1);
        check("len_err_proc_rst", proc_rst, 1);
        check("len_err_done", done, 0);
        send_word(32'h00000001, 1);
        send_word(32'hCAFEF00D, 1);
        wait_cyc(4);
        check("len_err_sticky", err, 1);
        check("len_err_we", 32'(we_cnt), 0);
        check("len_err_cnt", word_cnt, 0);

        // framing error on the 2nd data byte
        do_reset();
        send_word(32'h00000001, 0);
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b0, 0);
        wait_cyc(2);
        check("frame_err", err, 1);
        check("frame_err_done", done, 0);
        check("frame_err_proc_rst", proc_rst, 1);
        send_byte(8'h33, 1'b1, 0);
        send_byte(8'h44, 1'b1, 0);
        wait_cyc(4);
        check("frame_err_we", 32'(we_cnt), 0);

        // short glitch while idle, then a normal image
        do_reset();
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(3 * CPB);
        check("glitch_err", err, 0);
        check("glitch_done", done, 0);
        img_words = '{$urandom()};
        send_image(0);
        check_loaded("after_glitch", 1);

        // reset in the middle of word 0
        do_reset();
        img_words = '{32'h0BADF00D};
        send_word(32'h00000001, 0);
        send_byte(8'h0D, 1'b1, 0);
        send_byte(8'hF0, 1'b1, 0);
        wait_cyc(2);
        #3 rst = 1'b0;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_cnt", word_cnt, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_data", mem_data, 0);
        check("midrst_proc_rst", proc_rst, 1);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        do_reset();
        img_words = '{32'hA5A5A5A5};
        send_image(0);
        check_loaded("after_midrst", 1);

        // randomized images with random inter-byte gaps (including none)
        for (int t = 0; t < 4; t++) begin
            do_reset();
            n = $urandom_range(1, 4);
            img_words.delete();
            for (int i = 0; i < n; i++) img_words.push_back($urandom());
            send_image((t == 0) ? 0 : 20);
            check_loaded("rand", n);
            wc_before = word_cnt;
            send_word($urandom(), 5);
            wait_cyc(4);
            check("rand_post_cnt", word_cnt, wc_before);
            check("rand_post_we", 32'(we_cnt), 32'(n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
